// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM output stage:
// default widths, counter width, and the duty clamp helper.
package pwm_pkg;

  localparam int unsigned VAL_W_DEF        = 11;
  localparam int unsigned PWM_INTERVAL_DEF = 1200;
  localparam int unsigned CNT_W            = $clog2(PWM_INTERVAL_DEF);

  // Saturate a duty request to the period length (full-on).
  function automatic int unsigned clamp_duty(input int unsigned value,
                                             input int unsigned max_val);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty shadow, clamp, compare and pin flop.
// Ports:
//   clk, rst_n   clock and async active-low reset
//   i_enable     PWM running; 0 forces the pin inactive
//   i_load       capture the clamped duty into the shadow this cycle
//   i_cnt        shared period counter
//   i_duty       duty request from the upstream generator
//   o_pwm        registered pin, polarity set by ACTIVE_LOW
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned VAL_W        = VAL_W_DEF,
  parameter int unsigned PWM_INTERVAL = PWM_INTERVAL_DEF,
  parameter int unsigned CNT_BITS     = $clog2(PWM_INTERVAL),
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_enable,
  input  logic                i_load,
  input  logic [CNT_BITS-1:0] i_cnt,
  input  logic [VAL_W-1:0]    i_duty,
  output logic                o_pwm
);

  logic [VAL_W-1:0] r_shadow;
  logic             r_pwm;
  logic [VAL_W-1:0] w_clamp;
  logic             w_on;

  // Counter is never wider than the duty, so widening it is lossless.
  assign w_clamp = VAL_W'(clamp_duty(32'(i_duty), PWM_INTERVAL));
  assign w_on    = i_enable && (VAL_W'(i_cnt) < r_shadow);

  // Shadow only moves at a period boundary (or while idle) to avoid glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_pwm    <= ACTIVE_LOW;
    end else begin
      if (i_load) begin
        r_shadow <= w_clamp;
      end
      r_pwm <= w_on ^ ACTIVE_LOW;
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_driver.sv
// Multi-channel PWM output stage between the duty generators and LED pins.
// Ports:
//   clk, rst_n    clock and async active-low reset
//   enable        1 = run PWM; 0 = pins inactive, counter held at 0
//   duty_in       packed duties, channel i at [i*VAL_W +: VAL_W]
//   pwm_out       registered pins, polarity set by ACTIVE_LOW
//   period_start  one-cycle pulse aligned with the first output cycle of a period
module pwm_driver
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = PWM_INTERVAL_DEF,
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned VAL_W        = VAL_W_DEF,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NUM_CH*VAL_W-1:0] duty_in,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_start
);

  localparam int unsigned           CNT_BITS = $clog2(PWM_INTERVAL);
  localparam logic [CNT_BITS-1:0]   CNT_LAST = CNT_BITS'(PWM_INTERVAL - 1);

  logic [CNT_BITS-1:0] r_cnt;
  logic                r_period_start;
  logic                w_last;
  logic                w_load;

  assign w_last = (r_cnt == CNT_LAST);
  // Shadows track the input while idle so the first enabled period is current.
  assign w_load = !enable || w_last;

  // Shared period counter; period_start is registered to line up with the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= (!enable || w_last) ? '0 : r_cnt + CNT_BITS'(1);
      r_period_start <= enable && (r_cnt == '0);
    end
  end

  assign period_start = r_period_start;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .VAL_W        (VAL_W),
      .PWM_INTERVAL (PWM_INTERVAL),
      .CNT_BITS     (CNT_BITS),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_enable (enable),
      .i_load   (w_load),
      .i_cnt    (r_cnt),
      .i_duty   (duty_in[g*VAL_W +: VAL_W]),
      .o_pwm    (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_driver.sv
// Scoreboard bench for pwm_driver: an active-low and an active-high instance
// share stimulus; a period-level reference model predicts every output cycle.
module tb_pwm_driver;

  localparam int P   = 10;
  localparam int NCH = 3;
  localparam int VW  = 11;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [NCH*VW-1:0] duty_in;
  logic [NCH-1:0]    pwm_lo, pwm_hi;
  logic              ps_lo, ps_hi;

  pwm_driver #(.PWM_INTERVAL(P), .NUM_CH(NCH), .VAL_W(VW), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .enable(enable), .duty_in(duty_in),
    .pwm_out(pwm_lo), .period_start(ps_lo));

  pwm_driver #(.PWM_INTERVAL(P), .NUM_CH(NCH), .VAL_W(VW), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .enable(enable), .duty_in(duty_in),
    .pwm_out(pwm_hi), .period_start(ps_hi));

  typedef struct {
    int         tgt;
    logic [2:0] lo;
    logic [2:0] hi;
    logic       ps;
  } exp_t;

  exp_t sb_q[$];
  exp_t mid_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model state: position of the next output cycle in its period,
  // and the duty each channel shows during the current period.
  int m_pos = 0;
  int m_lat[NCH];
  int cur_d[NCH];

  // Test-6 tally of active-high cycles over 100 periods
  bit tally_arm = 0;
  bit t_active = 0;
  int t_periods = 0;
  int t_cnt[NCH];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clampd(input int d);
    return (d > P) ? P : d;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, req);
  endtask

  task automatic model_step(input bit rst, input bit en, output exp_t e);
    logic [2:0] on;
    on   = '0;
    e.ps = 1'b0;
    e.tgt = 0;
    if (rst) begin
      m_pos = 0;
      for (int i = 0; i < NCH; i++) m_lat[i] = 0;
    end else if (!en) begin
      m_pos = 0;
      for (int i = 0; i < NCH; i++) m_lat[i] = clampd(cur_d[i]);
    end else begin
      e.ps = (m_pos == 0);
      for (int i = 0; i < NCH; i++) on[i] = (m_pos < m_lat[i]);
      if (m_pos == P - 1) begin
        m_pos = 0;
        for (int i = 0; i < NCH; i++) m_lat[i] = clampd(cur_d[i]);
      end else begin
        m_pos++;
      end
    end
    e.hi = on;
    e.lo = ~on;
  endtask

  task automatic set_inputs(input bit en, input int d0, input int d1, input int d2);
    cur_d[0] = d0; cur_d[1] = d1; cur_d[2] = d2;
    enable  = en;
    duty_in = {VW'(d2), VW'(d1), VW'(d0)};
  endtask

  task automatic drive(input bit rst_hold, input bit en, input int d0, input int d1, input int d2);
    exp_t e;
    @(posedge clk); #1;
    rst_n = !rst_hold;
    set_inputs(en, d0, d1, d2);
    model_step(rst_hold, en, e);
    e.tgt = cyc + 1;
    sb_q.push_back(e);
  endtask

  // Reset pulled low between edges; pins must go inactive without a clock.
  task automatic drive_async_rst(input bit en, input int d0, input int d1, input int d2);
    exp_t e, m;
    @(posedge clk); #1;
    set_inputs(en, d0, d1, d2);
    m.tgt = cyc; m.lo = 3'b111; m.hi = 3'b000; m.ps = 1'b0;
    mid_q.push_back(m);
    model_step(1'b1, en, e);
    e.tgt = cyc + 1;
    sb_q.push_back(e);
    #3 rst_n = 1'b0;
  endtask

  // Edge monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #3;
      while (sb_q.size() > 0 && sb_q[0].tgt <= cyc) begin
        e = sb_q.pop_front();
        check("pwm_lo", 32'(pwm_lo), 32'(e.lo));
        check("pwm_hi", 32'(pwm_hi), 32'(e.hi));
        check("ps_lo",  32'(ps_lo),  32'(e.ps));
        check("ps_hi",  32'(ps_hi),  32'(e.ps));
      end
    end
  end

  // Mid-cycle monitor for asynchronous reset
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      while (mid_q.size() > 0 && mid_q[0].tgt <= cyc) begin
        e = mid_q.pop_front();
        check("async_rst_lo", 32'(pwm_lo), 32'(e.lo));
        check("async_rst_hi", 32'(pwm_hi), 32'(e.hi));
        check("async_rst_ps", 32'(ps_lo),  32'(e.ps));
      end
    end
  end

  // Count active cycles on the active-high instance over 100 whole periods
  initial begin
    forever begin
      @(negedge clk);
      if (tally_arm) begin
        if (ps_hi) begin
          if (t_periods < 100) begin
            t_periods++;
            t_active = 1'b1;
          end else begin
            t_active = 1'b0;
          end
        end
        if (t_active) for (int i = 0; i < NCH; i++) t_cnt[i] += int'(pwm_hi[i]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r_en;
    int rd[NCH];
    int t6[NCH];
    rst_n   = 1'b0;
    enable  = 1'b0;
    duty_in = '0;
    for (int i = 0; i < NCH; i++) begin m_lat[i] = 0; cur_d[i] = 0; t_cnt[i] = 0; end

    // Reset held
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 0, 0, 0);

    // 1: duty {0,5,10}
    for (int k = 0; k < 3 * P; k++) drive(1'b0, 1'b1, 0, 5, 10);

    // 2: ch1 3 -> 7 while the counter is at 4
    for (int k = 0; k < 3 * P; k++) begin
      drive(1'b0, 1'b1, 0, 3, 10);
      if (k >= P && m_pos == 4) break;
    end
    for (int k = 0; k < 25; k++) drive(1'b0, 1'b1, 0, 7, 10);

    // 3: out-of-range duty clamps to full-on
    for (int k = 0; k < 2 * P; k++) drive(1'b0, 1'b1, 2000, 7, 10);

    // 4: drop enable at count 2, re-enable with duty 4
    for (int k = 0; k < 3 * P; k++) begin
      drive(1'b0, 1'b1, 8, 8, 8);
      if (k >= P && m_pos == 2) break;
    end
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 4, 4, 4);
    for (int k = 0; k < 22; k++) drive(1'b0, 1'b1, 4, 4, 4);

    // 5: asynchronous reset mid-pulse, then restart from power-up state
    for (int k = 0; k < 3 * P; k++) begin
      drive(1'b0, 1'b1, 3, 6, 9);
      if (k >= P && m_pos == 2) break;
    end
    drive_async_rst(1'b1, 3, 6, 9);
    for (int k = 0; k < 25; k++) drive(1'b0, 1'b1, 3, 6, 9);

    // Randomized: duty changes at arbitrary times, enable toggles
    r_en = 1'b1;
    for (int i = 0; i < NCH; i++) rd[i] = 5;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 19) == 0) r_en = !r_en;
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 7) == 0)
          rd[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(11, 2047))
                                              : int'($urandom_range(0, 10));
      end
      drive(1'b0, r_en, rd[0], rd[1], rd[2]);
    end

    // 6: 100 periods of {1,9,0}, counted on the active-high instance
    t6[0] = 1; t6[1] = 9; t6[2] = 0;
    for (int k = 0; k < 2; k++) drive(1'b0, 1'b0, t6[0], t6[1], t6[2]);
    t_periods = 0;
    for (int i = 0; i < NCH; i++) t_cnt[i] = 0;
    tally_arm = 1'b1;
    for (int k = 0; k < 100 * P + 5; k++) drive(1'b0, 1'b1, t6[0], t6[1], t6[2]);
    @(negedge clk); @(negedge clk);
    tally_arm = 1'b0;
    check("t6_periods", 32'(t_periods), 32'(100));
    for (int i = 0; i < NCH; i++) check("t6_active_cycles", 32'(t_cnt[i]), 32'(100 * t6[i]));

    // Let the scoreboard drain
    for (int k = 0; k < 3; k++) @(posedge clk);
    #5;
    check("sb_drained", 32'(sb_q.size()), 32'(0));
    check("mid_drained", 32'(mid_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
